anspwm_combine_pwm: RTL and testbench



---
 rtl/anspwm_combine_pwm_if.sv | 24 ++
 rtl/anspwm_combine_pwm.sv | 86 ++++++++
 tb/tb_anspwm_combine_pwm.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/anspwm_combine_pwm_if.sv
// Purpose : bundles the stage-1/stage-2 operands going into the PWM combiner
//           and the PWM-side outputs coming back out of it.
// Ports   : A/C/Csgn (operands, master -> slave); pwm/tick/duty/sat (slave -> master).
interface anspwm_combine_pwm_if #(
  parameter int PW = 8
);
  logic [15:0] A;     // stage-1 quantized value, unsigned
  logic [15:0] C;     // stage-2 correction magnitude
  logic        Csgn;  // stage-2 correction sign, 1 = subtract
  logic        pwm;   // registered PWM pin
  logic        tick;  // one-clock pulse in the last cycle of each period
  logic [PW:0] duty;  // duty currently being output
  logic        sat;   // clamp flag for the active duty

  modport master (
    output A, C, Csgn,
    input  pwm, tick, duty, sat
  );

  modport slave (
    input  A, C, Csgn,
    output pwm, tick, duty, sat
  );
endinterface

// File: rtl/anspwm_combine_pwm.sv
// Purpose : signed add of stage-1 value and stage-2 correction, clamp to 0..2^PW,
//           load the result at each period boundary and drive a registered PWM pin.
// Latency : operands -> clamped duty in 2 clocks; loaded on the edge ending the tick cycle.
// Ports   : clk, rst_n (async active-low), bus (slave modport of anspwm_combine_pwm_if).
module anspwm_combine_pwm #(
  parameter int PW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  anspwm_combine_pwm_if.slave  bus
);

  localparam logic [PW-1:0] CNT_MAX  = '1;
  localparam logic [PW:0]   DUTY_MAX = {1'b1, {PW{1'b0}}};

  logic [17:0]   s_q;       // 18-bit two's complement sum, cannot overflow
  logic [17:0]   sum;
  logic [PW:0]   dnext;
  logic          snext;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_next;
  logic          tick_q;
  logic [PW:0]   duty_q;
  logic [PW:0]   duty_next;
  logic          sat_q;
  logic          pwm_q;

  // Stage-1 arithmetic; zero extension keeps A and C unsigned before negation.
  always_comb begin
    sum = {2'b00, bus.A} + (bus.Csgn ? -{2'b00, bus.C} : {2'b00, bus.C});
  end

  // Next-state values of the period counter and the active duty, used so the
  // PWM flop reflects the state after the edge (no glitch at the boundary).
  always_comb begin
    cnt_next  = cnt + PW'(1);
    duty_next = tick_q ? dnext : duty_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      dnext  <= '0;
      snext  <= 1'b0;
      cnt    <= '0;
      tick_q <= 1'b0;
      duty_q <= '0;
      sat_q  <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      // Pipeline stage 1: signed sum
      s_q <= sum;

      // Pipeline stage 2: clamp to 0..2^PW, flag when clipping happened
      if (s_q[17]) begin
        dnext <= '0;
        snext <= 1'b1;
      end else if (s_q > 18'(DUTY_MAX)) begin
        dnext <= DUTY_MAX;
        snext <= 1'b1;
      end else begin
        dnext <= s_q[PW:0];
        snext <= 1'b0;
      end

      // Free-running period counter; tick tracks the cycle where cnt is at max
      cnt    <= cnt_next;
      tick_q <= (cnt_next == CNT_MAX);

      // Duty and clamp flag only change on the edge that ends the tick cycle
      if (tick_q) begin
        duty_q <= dnext;
        sat_q  <= snext;
      end

      // Extra MSB on the counter so duty = 2^PW keeps the pin high all period
      pwm_q <= ({1'b0, cnt_next} < duty_next);
    end
  end

  assign bus.pwm  = pwm_q;
  assign bus.tick = tick_q;
  assign bus.duty = duty_q;
  assign bus.sat  = sat_q;

endmodule

// File: tb/tb_anspwm_combine_pwm.sv
// Purpose : self-checking bench for anspwm_combine_pwm with PW = 8.
// Ports   : none; drives the operand side of the interface, checks duty/sat/pwm/tick.
module tb_anspwm_combine_pwm;

  localparam int PW  = 8;
  localparam int PER = 1 << PW;

  logic clk;
  logic rst_n;

  anspwm_combine_pwm_if #(.PW(PW)) bus ();

  anspwm_combine_pwm #(.PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] c;
    logic        csgn;
    logic [PW:0] duty;
    logic        sat;
  } vec_t;

  typedef struct {
    logic [PW:0] duty;
    logic        sat;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_duty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] c, input logic csgn);
    bus.A    = a;
    bus.C    = c;
    bus.Csgn = csgn;
  endtask

  // Walks one full period starting at the negedge where cnt = 0, checking pwm,
  // tick and duty each cycle; optionally changes A (C=0, add) at cycle chg_at.
  task automatic run_period(input int exp_duty, input int chg_at, input logic [15:0] chg_a,
                            input string name);
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if ((bus.pwm !== (i < exp_duty)) || (bus.tick !== (i == PER - 1)) ||
          (bus.duty !== (PW + 1)'(exp_duty))) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i == chg_at) drive(chg_a, 16'd0, 1'b0);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad cycles (first at %0d) expected 0, duty %0d", name, bad,
               first_bad, exp_duty);
    end
  endtask

  // Crosses the boundary edge and compares the freshly loaded duty/sat against the scoreboard.
  task automatic load_and_check(input string name);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got duty %0d expected an entry", name, bus.duty);
    end else begin
      e = sb.pop_front();
      chk({name, "_duty"}, 32'(bus.duty), 32'(e.duty));
      chk({name, "_sat"}, 32'(bus.sat), 32'(e.sat));
      cur_duty = int'(e.duty);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'd100,    16'd20,     1'b1, 9'd80,  1'b0};
    vecs[1]  = '{16'd10,     16'd30,     1'b1, 9'd0,   1'b1};
    vecs[2]  = '{16'd0,      16'd0,      1'b1, 9'd0,   1'b0};
    vecs[3]  = '{16'd250,    16'd10,     1'b0, 9'd256, 1'b1};
    vecs[4]  = '{16'd250,    16'd10,     1'b0, 9'd256, 1'b1};
    vecs[5]  = '{16'hFFFF,   16'hFFFF,   1'b0, 9'd256, 1'b1};
    vecs[6]  = '{16'd256,    16'd0,      1'b0, 9'd256, 1'b0};
    vecs[7]  = '{16'd257,    16'd0,      1'b0, 9'd256, 1'b1};
    vecs[8]  = '{16'd0,      16'd1,      1'b1, 9'd0,   1'b1};
    vecs[9]  = '{16'd255,    16'd0,      1'b1, 9'd255, 1'b0};
    vecs[10] = '{16'd100,    16'd20,     1'b1, 9'd80,  1'b0};

    // Reset and reset-state checks
    rst_n = 1'b0;
    drive(16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(bus.pwm), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_duty", 32'(bus.duty), 0);
    chk("rst_sat", 32'(bus.sat), 0);
    rst_n = 1'b1;

    // First period: pwm low throughout, first tick exactly 255 clocks after release
    sb.push_back('{9'd0, 1'b0});
    run_period(0, -1, 16'd0, "first_period");
    load_and_check("first_load");

    // Table-driven vectors: operands presented at cnt=0, loaded at the next boundary,
    // and the resulting waveform checked over the following period.
    foreach (vecs[k]) begin
      drive(vecs[k].a, vecs[k].c, vecs[k].csgn);
      sb.push_back('{vecs[k].duty, vecs[k].sat});
      run_period(cur_duty, -1, 16'd0, $sformatf("vec%0d_period", k));
      load_and_check($sformatf("vec%0d_load", k));
    end

    // Mid-period change at cnt=40 must not disturb the active duty of 80
    sb.push_back('{9'd200, 1'b0});
    run_period(cur_duty, 40, 16'd200, "midchg_period");
    load_and_check("midchg_load");

    // Change one cycle before the tick: old value loaded first, new one a period later
    sb.push_back('{9'd200, 1'b0});
    run_period(cur_duty, PER - 2, 16'd30, "late_period");
    load_and_check("late_load_old");
    sb.push_back('{9'd30, 1'b0});
    run_period(cur_duty, -1, 16'd0, "late_period2");
    load_and_check("late_load_new");

    // Reset mid-period with duty 80 active
    drive(16'd80, 16'd0, 1'b0);
    sb.push_back('{9'd80, 1'b0});
    run_period(cur_duty, -1, 16'd0, "pre_rst_period");
    load_and_check("pre_rst_load");
    repeat (50) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_pwm_high", 32'(bus.pwm), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pwm", 32'(bus.pwm), 0);
    chk("midrst_duty", 32'(bus.duty), 0);
    chk("midrst_sat", 32'(bus.sat), 0);
    chk("midrst_tick", 32'(bus.tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{9'd80, 1'b0});
    run_period(0, -1, 16'd0, "post_rst_period");
    load_and_check("post_rst_load");
    run_period(cur_duty, -1, 16'd0, "post_rst_duty80");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
